multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for a small RV32 subset.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction and
// bounds every memory handshake with a wait counter. A timeout or an illegal
// encoding parks the controller in TRAP until reset.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic        imem_ack_i,
  input  logic        dmem_ack_i,
  input  logic        zero_i,
  output logic        imem_req_o,
  output logic        dmem_re_o,
  output logic        dmem_we_o,
  output logic        ir_we_o,
  output logic [4:0]  ALUop_o,
  output logic        ALUSrc1_o,
  output logic        ALUSrc2_o,
  output logic        reg_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic [2:0]  state_o,
  output logic        trap_o,
  output logic [31:0] instret_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU  = 3'd0,
    C_LW   = 3'd1,
    C_SW   = 3'd2,
    C_BEQ  = 3'd3,
    C_JALR = 3'd4
  } cls_t;

  state_t      state;
  logic        run;        // low until the first clock edge after reset
  logic [3:0]  wait_cnt;
  logic        wait_hit;

  // latched IR fields
  logic [6:0]  ir_opcode;
  logic [2:0]  ir_funct3;
  logic [6:0]  ir_funct7;

  // decoded instruction, latched at the end of DECODE
  cls_t        op_cls;
  logic [4:0]  op_alu;
  logic        op_rtype;

  // combinational decode of the latched IR
  logic        dec_legal;
  cls_t        dec_cls;
  logic [4:0]  dec_alu;
  logic        dec_rtype;

  logic [31:0] instret;

  // register/immediate fields are consumed by the datapath, not here
  logic        unused_instr_bits;
  assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

  // the wait counter reaches the limit on this edge; an ack this cycle still wins
  assign wait_hit = ({1'b0, wait_cnt} + 5'd1) == 5'(MEM_TIMEOUT);

  // decode opcode/funct3/funct7 into an instruction class and ALU code
  always_comb begin
    dec_legal = 1'b0;
    dec_cls   = C_ALU;
    dec_alu   = 5'b00000;
    dec_rtype = 1'b0;
    case (ir_opcode)
      7'b0110011: begin
        dec_rtype = 1'b1;
        dec_legal = 1'b1;
        case ({ir_funct7, ir_funct3})
          {7'b0000000, 3'b000}: dec_alu = 5'b01101; // add
          {7'b0100000, 3'b000}: dec_alu = 5'b01110; // sub
          {7'b0000000, 3'b001}: dec_alu = 5'b01000; // sll
          {7'b0000000, 3'b100}: dec_alu = 5'b00110; // xor
          {7'b0000000, 3'b101}: dec_alu = 5'b01001; // srl
          {7'b0000000, 3'b110}: dec_alu = 5'b00101; // or
          {7'b0000000, 3'b111}: dec_alu = 5'b00100; // and
          default:              dec_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        if (ir_funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_alu   = 5'b01100;                   // addi
        end
      end
      7'b0000011: begin
        if (ir_funct3 == 3'b010) begin
          dec_legal = 1'b1;
          dec_cls   = C_LW;
          dec_alu   = 5'b10100;
        end
      end
      7'b0100011: begin
        if (ir_funct3 == 3'b010) begin
          dec_legal = 1'b1;
          dec_cls   = C_SW;
          dec_alu   = 5'b10101;
        end
      end
      7'b1100011: begin
        if (ir_funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_cls   = C_BEQ;
          dec_alu   = 5'b10001;
        end
      end
      7'b1100111: begin
        if (ir_funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_cls   = C_JALR;
          dec_alu   = 5'b10100;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // main FSM: state, wait counter, IR fields and decoded instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      run       <= 1'b0;
      wait_cnt  <= 4'd0;
      ir_opcode <= 7'd0;
      ir_funct3 <= 3'd0;
      ir_funct7 <= 7'd0;
      op_cls    <= C_ALU;
      op_alu    <= 5'd0;
      op_rtype  <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FETCH: begin
          if (run) begin
            if (imem_ack_i) begin
              ir_opcode <= instr_i[6:0];
              ir_funct3 <= instr_i[14:12];
              ir_funct7 <= instr_i[31:25];
              wait_cnt  <= 4'd0;
              state     <= S_DECODE;
            end else if (wait_hit) begin
              wait_cnt  <= 4'd0;
              state     <= S_TRAP;
            end else begin
              wait_cnt  <= wait_cnt + 4'd1;
            end
          end
        end
        S_DECODE: begin
          wait_cnt <= 4'd0;
          op_cls   <= dec_cls;
          op_alu   <= dec_alu;
          op_rtype <= dec_rtype;
          state    <= dec_legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          wait_cnt <= 4'd0;
          case (op_cls)
            C_LW, C_SW: state <= S_MEM;
            C_BEQ:      state <= S_FETCH;
            default:    state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ack_i) begin
            wait_cnt <= 4'd0;
            state    <= (op_cls == C_LW) ? S_WB : S_FETCH;
          end else if (wait_hit) begin
            wait_cnt <= 4'd0;
            state    <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_WB: begin
          wait_cnt <= 4'd0;
          state    <= S_FETCH;
        end
        S_TRAP: begin
          wait_cnt <= 4'd0;
          state    <= S_TRAP;
        end
        default: begin
          wait_cnt <= 4'd0;
          state    <= S_TRAP;
        end
      endcase
    end
  end

  // control outputs decoded from the state and the latched instruction
  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_re_o  = 1'b0;
    dmem_we_o  = 1'b0;
    ALUop_o    = 5'b00000;
    ALUSrc1_o  = 1'b0;
    ALUSrc2_o  = 1'b0;
    reg_we_o   = 1'b0;
    wb_sel_o   = 2'd0;
    pc_we_o    = 1'b0;
    pc_sel_o   = 1'b0;
    trap_o     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_o = run;
        ir_we_o    = run & imem_ack_i;
      end
      S_EXEC: begin
        ALUop_o   = op_alu;
        ALUSrc1_o = (op_cls == C_BEQ);
        ALUSrc2_o = ~op_rtype;
        // beq retires here; zero_i steers the next PC straight through
        if (op_cls == C_BEQ) begin
          pc_we_o  = 1'b1;
          pc_sel_o = zero_i;
        end
      end
      S_MEM: begin
        ALUop_o   = op_alu;
        dmem_re_o = (op_cls == C_LW);
        dmem_we_o = (op_cls == C_SW);
        // a store retires in its ack cycle
        pc_we_o   = (op_cls == C_SW) & dmem_ack_i;
      end
      S_WB: begin
        ALUop_o  = op_alu;
        reg_we_o = 1'b1;
        pc_we_o  = 1'b1;
        case (op_cls)
          C_LW:    wb_sel_o = 2'd1;
          C_JALR: begin
            wb_sel_o = 2'd2;
            pc_sel_o = 1'b1;
          end
          default: wb_sel_o = 2'd0;
        endcase
      end
      S_TRAP: trap_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

  // retired-instruction counter, one step per PC update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= 32'd0;
    end else if (pc_we_o) begin
      instret <= instret + 32'd1;
    end
  end

  assign instret_o = instret;

endmodule
